camera_capture: RTL and testbench

- Upstream producer for the VGA playback stage: captures OV7670-style RGB444 camera frames and writes them into the 640x480 frame buffer.
- Writes to the same linear address space the display side reads (addr = row*640 + col), 12-bit pixel format 4R:4G:4B.
- Sampled on the display clock domain; camera PCLK is treated as a data signal and edge-detected (video_clk must be at least 2x PCLK).
- Supports continuous capture or single-shot capture via an arm/done handshake.

---
 rtl/video_pkg.sv | 27 ++
 rtl/cam_sync_edge.sv | 37 +++
 rtl/camera_capture.sv | 179 +++++++++++++++++
 tb/tb_camera_capture.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video definitions for the capture and display stages.
package video_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned FB_DEPTH = H_ACTIVE * V_ACTIVE;
   localparam int unsigned ADDR_W   = 19;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_FRAME,
      CAPTURE,
      DONE
   } cap_state_e;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } pixel_t;

   // Luma approximation Y = R/4 + G/2 + G/8 + B/8, wrapped to 4 bits
   function automatic logic [3:0] gray_y(input pixel_t p);
      return (p.r >> 2) + (p.g >> 1) + (p.g >> 3) + (p.b >> 3);
   endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// N-stage synchronizer for one camera control bit with rise/fall detection.
module cam_sync_edge #(
   parameter int unsigned N = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic level,
   output logic rise_c,
   output logic fall_c
);

   logic [N-1:0] sync_q, sync_d;
   logic         prev_q, prev_d;

   // Shift the raw input through the chain; remember last synced value
   always_comb begin
      sync_d = {sync_q[N-2:0], d};
      prev_d = sync_q[N-1];
   end

   // Synchronizer and history registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level  = sync_q[N-1];
   assign rise_c = sync_q[N-1] & ~prev_q;
   assign fall_c = ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/camera_capture.sv
// OV7670-style RGB444 capture into the linear frame buffer (addr = row*H + col).
// Optional GRAYSCALE_EN: write {Y,Y,Y} luma instead of raw RGB444.
module camera_capture #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned ADDR_W      = 19,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              video_clk,
   input  logic              reset_n,
   input  logic              cam_pclk,
   input  logic              cam_href,
   input  logic              cam_vsync,
   input  logic [7:0]        cam_data,
   input  logic              continuous,
   input  logic              arm,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [11:0]       mem_data,
   output logic              mem_we,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_err
);
   import video_pkg::*;

   localparam int unsigned COL_W = $clog2(H_ACTIVE + 1);
   localparam int unsigned ROW_W = $clog2(V_ACTIVE + 1);

   logic pclk_rise, href_lvl, href_fall, vsync_rise, vsync_fall;
   logic unused_pclk_lvl, unused_pclk_fall, unused_href_rise, unused_vsync_lvl;

   logic [SYNC_STAGES-1:0][7:0] dsync_q, dsync_d;
   logic [7:0]                  byte_c;

   cap_state_e        state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
   logic              phase_q, phase_d;
   logic [3:0]        red_q, red_d;
   logic [11:0]       data_q, data_d;
   logic              we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   pixel_t            pix_c;
   logic [11:0]       wr_data_c;

   cam_sync_edge #(.N(SYNC_STAGES)) u_pclk (
      .clk(video_clk), .rst_n(reset_n), .d(cam_pclk),
      .level(unused_pclk_lvl), .rise_c(pclk_rise), .fall_c(unused_pclk_fall));
   cam_sync_edge #(.N(SYNC_STAGES)) u_href (
      .clk(video_clk), .rst_n(reset_n), .d(cam_href),
      .level(href_lvl), .rise_c(unused_href_rise), .fall_c(href_fall));
   cam_sync_edge #(.N(SYNC_STAGES)) u_vsync (
      .clk(video_clk), .rst_n(reset_n), .d(cam_vsync),
      .level(unused_vsync_lvl), .rise_c(vsync_rise), .fall_c(vsync_fall));

   // Data byte shares the control-bit synchronizer depth to stay aligned
   always_comb begin
      dsync_d = {dsync_q[SYNC_STAGES-2:0], cam_data};
      byte_c  = dsync_q[SYNC_STAGES-1];
   end

   // Pixel assembled from the latched red nibble and the second byte
   always_comb begin
      pix_c = {red_q, byte_c};
`ifdef GRAYSCALE_EN
      wr_data_c = {3{gray_y(pix_c)}};
`else
      wr_data_c = pix_c;
`endif
   end

   // Next-state, byte pairing, counters and output strobes
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      base_d  = base_q;
      phase_d = phase_q;
      red_d   = red_q;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (arm) err_d = 1'b0;
            if (continuous || arm) state_d = WAIT_FRAME;
         end
         WAIT_FRAME: begin
            col_d   = '0;
            row_d   = '0;
            base_d  = '0;
            phase_d = 1'b0;
            if (vsync_fall) state_d = CAPTURE;
         end
         CAPTURE: begin
            if (vsync_rise) begin
               state_d = DONE;
            end else begin
               // href_fall in the same cycle still counts the edge as in-line
               if (pclk_rise && (href_lvl || href_fall)) begin
                  if (!phase_q) begin
                     red_d   = byte_c[3:0];
                     phase_d = 1'b1;
                  end else begin
                     phase_d = 1'b0;
                     if (col_q < COL_W'(H_ACTIVE)) begin
                        col_d = col_q + COL_W'(1);
                        if (row_q < ROW_W'(V_ACTIVE)) begin
                           we_d   = 1'b1;
                           data_d = wr_data_c;
                           addr_d = base_q + ADDR_W'(col_q);
                        end
                     end
                  end
               end
               // Line end applied after any same-cycle pixel update
               if (href_fall) begin
                  if ((col_d != '0) && (row_q < ROW_W'(V_ACTIVE))) begin
                     row_d  = row_q + ROW_W'(1);
                     base_d = base_q + ADDR_W'(H_ACTIVE);
                  end
                  col_d   = '0;
                  phase_d = 1'b0;
               end
            end
         end
         DONE: begin
            done_d = 1'b1;
            if (row_q != ROW_W'(V_ACTIVE)) err_d = 1'b1;
            state_d = continuous ? WAIT_FRAME : IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State, counters and registered outputs
   always_ff @(posedge video_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         dsync_q <= '0;
         col_q   <= '0;
         row_q   <= '0;
         base_q  <= '0;
         phase_q <= 1'b0;
         red_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dsync_q <= dsync_d;
         col_q   <= col_d;
         row_q   <= row_d;
         base_q  <= base_d;
         phase_q <= phase_d;
         red_q   <= red_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign mem_addr   = addr_q;
   assign mem_data   = data_q;
   assign mem_we     = we_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign frame_err  = err_q;

endmodule

// File: tb/tb_camera_capture.sv
// Randomized scoreboard bench for camera_capture on a reduced 16x8 frame.
module tb_camera_capture;

   localparam int H = 16;
   localparam int V = 8;

   logic        video_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cam_pclk = 1'b0;
   logic        cam_href = 1'b0;
   logic        cam_vsync = 1'b1;
   logic [7:0]  cam_data = 8'h00;
   logic        continuous = 1'b0;
   logic        arm = 1'b0;
   logic [7:0]  mem_addr;
   logic [11:0] mem_data;
   logic        mem_we, busy, frame_done, frame_err;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int wr_cnt = 0;
   int last_addr = -1;
   int mrow = 0;
   logic [19:0] exp_q[$];
   logic [19:0] exp_e;

   camera_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(8), .SYNC_STAGES(2)) dut (
      .video_clk(video_clk), .reset_n(reset_n), .cam_pclk(cam_pclk), .cam_href(cam_href),
      .cam_vsync(cam_vsync), .cam_data(cam_data), .continuous(continuous), .arm(arm),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .busy(busy),
      .frame_done(frame_done), .frame_err(frame_err));

   always #5 video_clk = ~video_clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Expected frame-buffer word from a camera byte pair
   function automatic logic [11:0] expect_pix(input logic [7:0] b0, input logic [7:0] b1);
      int r, g, b, y;
      r = int'(b0[3:0]);
      g = int'(b1[7:4]);
      b = int'(b1[3:0]);
`ifdef GRAYSCALE_EN
      y = (r / 4 + g / 2 + g / 8 + b / 8) % 16;
      return 12'(y * 273);
`else
      y = 0;
      return 12'(r * 256 + g * 16 + b + y);
`endif
   endfunction

   // Monitor: every write must match the head of the expected queue
   always @(negedge video_clk) begin
      if (reset_n && frame_done) done_cnt++;
      if (reset_n && mem_we) begin
         wr_cnt++;
         last_addr = int'(mem_addr);
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: addr %0d data %03h, none expected", mem_addr, mem_data);
         end else begin
            exp_e = exp_q.pop_front();
            if ({mem_addr, mem_data} !== exp_e) begin
               fails++;
               $display("FAIL write: addr %0d data %03h, expected addr %0d data %03h",
                        mem_addr, mem_data, exp_e[19:12], exp_e[11:0]);
            end
         end
      end
   end

   task automatic clks(input int n);
      repeat (n) @(negedge video_clk);
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      clks(1);
      arm = 1'b0;
   endtask

   task automatic frame_start();
      cam_vsync = 1'b0;
      mrow = 0;
      clks(8);
   endtask

   task automatic frame_end();
      cam_vsync = 1'b1;
      clks(10);
   endtask

   // One camera line: mode 0 random, 1 test pattern, 2 all 0xFF; joint drops href with last pclk rise
   task automatic send_line(input int n, input bit capt, input int mode, input bit joint);
      logic [7:0] b[$];
      logic [7:0] v;
      int npix;
      for (int i = 0; i < n; i++) begin
         case (mode)
            1:       v = (i % 2 == 0) ? 8'((i / 2) % 16) : 8'((mrow % 16) * 16 + 10);
            2:       v = 8'hFF;
            default: v = 8'($urandom);
         endcase
         b.push_back(v);
      end
      npix = n / 2;
      if (capt) begin
         for (int k = 0; k < npix; k++)
            if (k < H && mrow < V)
               exp_q.push_back({8'(mrow * H + k), expect_pix(b[2*k], b[2*k+1])});
         if (npix > 0 && mrow < V) mrow++;
      end
      cam_href = 1'b1;
      clks(2);
      for (int i = 0; i < n; i++) begin
         cam_data = b[i];
         cam_pclk = 1'b0;
         clks(2);
         cam_pclk = 1'b1;
         if (joint && i == n - 1) cam_href = 1'b0;
         clks(2);
      end
      cam_pclk = 1'b0;
      cam_href = 1'b0;
      clks(6);
   endtask

   initial begin
      clks(3);
      check("reset_we", int'(mem_we), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(frame_done), 0);
      check("reset_err", int'(frame_err), 0);
      check("reset_addr", int'(mem_addr), 0);
      check("reset_data", int'(mem_data), 0);
      reset_n = 1'b1;
      clks(3);

      // Continuous capture of a full pattern frame
      continuous = 1'b1;
      clks(4);
      check("busy_continuous", int'(busy), 1);
      wr_cnt = 0;
      frame_start();
      for (int r = 0; r < V; r++) send_line(2 * H, 1'b1, 1, 1'b0);
      frame_end();
      check("t1_done", done_cnt, 1);
      check("t1_err", int'(frame_err), int'(mrow != V));
      check("t1_writes", wr_cnt, H * V);
      check("t1_last_addr", last_addr, H * V - 1);
      check("t1_pending", exp_q.size(), 0);

      // Random frame, continuous cleared mid-frame, one line with coincident edges
      frame_start();
      for (int r = 0; r < V; r++) begin
         if (r == 3) continuous = 1'b0;
         send_line(2 * H, 1'b1, 0, r == 5);
      end
      frame_end();
      check("t2_done", done_cnt, 2);
      check("t2_busy", int'(busy), 0);
      check("t2_err", int'(frame_err), int'(mrow != V));
      check("t2_pending", exp_q.size(), 0);

      // Single shot with a second arm mid-frame, then two uncaptured frames
      pulse_arm();
      clks(2);
      check("t3_busy_armed", int'(busy), 1);
      frame_start();
      for (int r = 0; r < V; r++) begin
         if (r == 2) pulse_arm();
         send_line(2 * H, 1'b1, 0, 1'b0);
      end
      frame_end();
      check("t3_done", done_cnt, 3);
      check("t3_busy", int'(busy), 0);
      wr_cnt = 0;
      for (int f = 0; f < 2; f++) begin
         frame_start();
         for (int r = 0; r < V; r++) send_line(2 * H, 1'b0, 0, 1'b0);
         frame_end();
      end
      check("t3_idle_writes", wr_cnt, 0);
      check("t3_idle_done", done_cnt, 3);

      // Overlong line, odd byte count line, all-ones pixel line
      pulse_arm();
      frame_start();
      for (int r = 0; r < V; r++) begin
         if (r == 1) send_line(2 * H + 20, 1'b1, 0, 1'b0);
         else if (r == 2) send_line(2 * H + 1, 1'b1, 0, 1'b0);
         else if (r == 4) send_line(2 * H, 1'b1, 2, 1'b0);
         else send_line(2 * H, 1'b1, 0, 1'b0);
      end
      frame_end();
      check("t4_done", done_cnt, 4);
      check("t4_err", int'(frame_err), int'(mrow != V));
      check("t4_pending", exp_q.size(), 0);

      // Short frame sets the sticky error; next arm clears it
      pulse_arm();
      frame_start();
      for (int r = 0; r < 3; r++) send_line(2 * H, 1'b1, 0, 1'b0);
      frame_end();
      check("t5_done", done_cnt, 5);
      check("t5_err", int'(frame_err), int'(mrow != V));
      pulse_arm();
      clks(2);
      check("t5_err_cleared", int'(frame_err), 0);

      // Asynchronous reset mid-frame, then restart from address 0
      continuous = 1'b1;
      frame_start();
      for (int r = 0; r < 3; r++) send_line(2 * H, 1'b1, 0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_we", int'(mem_we), 0);
      check("t6_rst_busy", int'(busy), 0);
      check("t6_rst_addr", int'(mem_addr), 0);
      check("t6_rst_data", int'(mem_data), 0);
      clks(2);
      reset_n = 1'b1;
      for (int r = 3; r < V; r++) send_line(2 * H, 1'b0, 0, 1'b0);
      frame_end();
      check("t6_no_done", done_cnt, 5);
      wr_cnt = 0;
      frame_start();
      for (int r = 0; r < V; r++) send_line(2 * H, 1'b1, 0, 1'b0);
      frame_end();
      check("t6_done", done_cnt, 6);
      check("t6_err", int'(frame_err), int'(mrow != V));
      check("t6_writes", wr_cnt, H * V);
      check("t6_pending", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
